t05_ssd_capture: RTL and testbench

// Receive side of the team's seven-segment display interface: samples a time-multiplexed

---
 rtl/t05_ssd_capture_if.sv | 21 ++
 rtl/t05_ssd_capture.sv | 143 ++++++++++++++
 tb/tb_t05_ssd_capture.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/t05_ssd_capture_if.sv
// Seven-segment scan bus between a display driver and the capture block.
// Ports: seg/digit_sel carry the scanned display; seq/blank/bad/frame_valid
// return the rebuilt frame. master = scan source, slave = capture block.
interface t05_ssd_capture_if;
  logic [7:0]  seg;          // {dp,g,f,e,d,c,b,a}
  logic [7:0]  digit_sel;    // one-hot digit select
  logic [31:0] seq;          // nibble i = digit i
  logic [7:0]  blank;        // digit i all segments off
  logic [7:0]  bad;          // digit i pattern undecodable
  logic        frame_valid;  // one-cycle pulse on frame update

  modport master (
    output seg, digit_sel,
    input  seq, blank, bad, frame_valid
  );

  modport slave (
    input  seg, digit_sel,
    output seq, blank, bad, frame_valid
  );
endinterface

// File: rtl/t05_ssd_capture.sv
// Purpose: rebuild the 32-bit hex word from a time-multiplexed 8-digit seven-segment scan.
// Latency: digit stable at the pins from edge k commits at edge k+STABLE_CYCLES; frame publishes one edge later.
// Backpressure: none; the scan source is free-running and outputs hold until the next complete frame.
// Ports: clk, nrst (sync, active-low); bus.slave: seg/digit_sel in, seq/blank/bad/frame_valid out.
module t05_ssd_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             nrst,
  t05_ssd_capture_if.slave bus
);

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;
  localparam logic [3:0] STABLE  = 4'(STABLE_CYCLES);

  logic [14:0] sample_q, sample_d;   // {seg[6:0], digit_sel}
  logic [14:0] prev_q, prev_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [0:0]  state_q, state_d;
  logic [7:0]  mask_q, mask_d;
  logic [31:0] sh_nib_q, sh_nib_d;
  logic [7:0]  sh_blank_q, sh_blank_d;
  logic [7:0]  sh_bad_q, sh_bad_d;
  logic        pub_q, pub_d;
  logic [31:0] seq_q, seq_d;
  logic [7:0]  blank_q, blank_d;
  logic [7:0]  bad_q, bad_d;
  logic        fv_q, fv_d;

  logic        one_hot;
  logic        changed;
  logic        commit;
  logic [5:0]  dec;                  // {bad, blank, nibble}
  logic        unused_dp;

  // Decimal point carries no hex information.
  assign unused_dp = bus.seg[7];

  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'h3F: decode = 6'h00;
      7'h06: decode = 6'h01;
      7'h5B: decode = 6'h02;
      7'h4F: decode = 6'h03;
      7'h66: decode = 6'h04;
      7'h6D: decode = 6'h05;
      7'h7D: decode = 6'h06;
      7'h07: decode = 6'h07;
      7'h7F: decode = 6'h08;
      7'h6F: decode = 6'h09;
      7'h77: decode = 6'h0A;
      7'h7C: decode = 6'h0B;
      7'h39: decode = 6'h0C;
      7'h5E: decode = 6'h0D;
      7'h79: decode = 6'h0E;
      7'h71: decode = 6'h0F;
      7'h00: decode = 6'b01_0000;
      default: decode = 6'b10_0000;
    endcase
  endfunction

  always_comb begin
    sample_d = {bus.seg[6:0], bus.digit_sel};
    prev_d   = sample_q;
    one_hot  = $onehot(sample_q[7:0]);
    changed  = (sample_q != prev_q);

    // A new valid sample counts as its own first stable cycle.
    if (!one_hot)             cnt_d = 4'd0;
    else if (changed)         cnt_d = 4'd1;
    else if (cnt_q == 4'hF)   cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 4'd1;

    // In HELD only a fresh sample (changed) may commit, which is what lets
    // STABLE_CYCLES=1 commit back-to-back dwells without passing through WAIT.
    commit = one_hot && (cnt_d == STABLE) && ((state_q == ST_WAIT) || changed);

    if (commit)                   state_d = ST_HELD;
    else if (!one_hot || changed) state_d = ST_WAIT;
    else                          state_d = state_q;

    dec        = decode(sample_q[14:8]);
    sh_nib_d   = sh_nib_q;
    sh_blank_d = sh_blank_q;
    sh_bad_d   = sh_bad_q;
    // A pending publish empties the mask on this edge; a commit landing on
    // the same edge starts the next frame.
    mask_d     = pub_q ? 8'h00 : mask_q;
    for (int i = 0; i < 8; i++) begin
      if (commit && sample_q[i]) begin
        sh_nib_d[4*i +: 4] = dec[3:0];
        sh_blank_d[i]      = dec[4];
        sh_bad_d[i]        = dec[5];
        mask_d[i]          = 1'b1;
      end
    end
    pub_d = commit && (mask_d == 8'hFF);

    seq_d   = pub_q ? sh_nib_q   : seq_q;
    blank_d = pub_q ? sh_blank_q : blank_q;
    bad_d   = pub_q ? sh_bad_q   : bad_q;
    fv_d    = pub_q;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      sample_q   <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      state_q    <= ST_WAIT;
      mask_q     <= '0;
      sh_nib_q   <= '0;
      sh_blank_q <= '0;
      sh_bad_q   <= '0;
      pub_q      <= 1'b0;
      seq_q      <= '0;
      blank_q    <= '0;
      bad_q      <= '0;
      fv_q       <= 1'b0;
    end else begin
      sample_q   <= sample_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      mask_q     <= mask_d;
      sh_nib_q   <= sh_nib_d;
      sh_blank_q <= sh_blank_d;
      sh_bad_q   <= sh_bad_d;
      pub_q      <= pub_d;
      seq_q      <= seq_d;
      blank_q    <= blank_d;
      bad_q      <= bad_d;
      fv_q       <= fv_d;
    end
  end

  assign bus.seq         = seq_q;
  assign bus.blank       = blank_q;
  assign bus.bad         = bad_q;
  assign bus.frame_valid = fv_q;

endmodule

// File: tb/tb_t05_ssd_capture.sv
// Bench for t05_ssd_capture: directed scans plus random dwells, checked every
// cycle against a run-length based model of the scan, plus literal frame values.
module tb_t05_ssd_capture;
  localparam int S = 4;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  t05_ssd_capture_if bus();

  t05_ssd_capture #(.STABLE_CYCLES(S)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // ---------------- reference model ----------------
  logic [6:0]  m_last_seg;
  logic [7:0]  m_last_sel;
  bit          m_last_v;
  int          m_run;
  bit          m_c_pend;          // commit due on the next edge
  logic [6:0]  m_c_seg;
  logic [7:0]  m_c_sel;
  logic [3:0]  m_nib [8];
  logic [7:0]  m_blk, m_bad, m_mask;
  bit          m_p_pend;          // publish due on the next edge
  logic [31:0] m_p_seq;
  logic [7:0]  m_p_blk, m_p_bad;
  logic [31:0] e_seq;
  logic [7:0]  e_blank, e_bad;
  logic        e_fv;

  task automatic model_decode(input logic [6:0] s, output logic [3:0] nib,
                              output logic bl, output logic bd);
    nib = 4'h0; bl = 1'b0; bd = 1'b0;
    if (s == 7'h00) bl = 1'b1;
    else begin
      bd = 1'b1;
      for (int k = 0; k < 16; k++)
        if (seg_tab[k] == s) begin nib = 4'(k); bd = 1'b0; end
    end
  endtask

  task automatic model_step(input logic [7:0] seg_i, input logic [7:0] sel_i, input logic rn);
    logic [3:0] nib;
    logic bl, bd;
    if (!rn) begin
      m_last_v = 0; m_run = 0; m_c_pend = 0; m_p_pend = 0;
      m_blk = 0; m_bad = 0; m_mask = 0;
      for (int k = 0; k < 8; k++) m_nib[k] = 4'h0;
      e_seq = 0; e_blank = 0; e_bad = 0; e_fv = 0;
      return;
    end
    e_fv = 1'b0;
    if (m_p_pend) begin
      e_seq = m_p_seq; e_blank = m_p_blk; e_bad = m_p_bad; e_fv = 1'b1;
      m_mask = 8'h00; m_p_pend = 0;
    end
    if (m_c_pend) begin
      model_decode(m_c_seg, nib, bl, bd);
      for (int k = 0; k < 8; k++)
        if (m_c_sel[k]) begin
          m_nib[k] = nib; m_blk[k] = bl; m_bad[k] = bd; m_mask[k] = 1'b1;
        end
      if (m_mask == 8'hFF) begin
        m_p_pend = 1;
        for (int k = 0; k < 8; k++) m_p_seq[4*k +: 4] = m_nib[k];
        m_p_blk = m_blk; m_p_bad = m_bad;
      end
      m_c_pend = 0;
    end
    // Length of the current run of identical one-hot pin values.
    if ($countones(sel_i) == 1) begin
      if (m_last_v && m_last_seg == seg_i[6:0] && m_last_sel == sel_i) m_run++;
      else m_run = 1;
      m_last_v = 1; m_last_seg = seg_i[6:0]; m_last_sel = sel_i;
    end else begin
      m_run = 0; m_last_v = 0;
    end
    if (m_run == S) begin
      m_c_pend = 1; m_c_seg = seg_i[6:0]; m_c_sel = sel_i;
    end
  endtask

  // ---------------- checking / driving ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] s, input logic [7:0] d, input logic r);
    @(negedge clk);
    bus.seg = s; bus.digit_sel = d; nrst = r;
    @(posedge clk);
    #1;
    model_step(s, d, r);
    check("frame_valid", {31'b0, bus.frame_valid}, {31'b0, e_fv});
    check("seq", bus.seq, e_seq);
    check("blank", {24'b0, bus.blank}, {24'b0, e_blank});
    check("bad", {24'b0, bus.bad}, {24'b0, e_bad});
    if (bus.frame_valid === 1'b1) pulses++;
  endtask

  task automatic dwell(input int dig, input logic [7:0] s, input int len);
    for (int k = 0; k < len; k++) cyc(s, 8'(1 << dig), 1'b1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(8'h00, 8'h00, 1'b1);
  endtask

  initial begin
    int p0;
    logic [7:0] s, d;
    bus.seg = 0; bus.digit_sel = 0; nrst = 0;

    cyc(8'h00, 8'h00, 1'b0);
    check("reset_seq", bus.seq, 32'h0);
    check("reset_fv", {31'b0, bus.frame_valid}, 32'h0);
    idle(2);

    // 1: digits 0..7 show 1..8
    p0 = pulses;
    for (int i = 0; i < 8; i++) dwell(i, {1'b0, seg_tab[i+1]}, 6);
    idle(2);
    check("t1_pulses", pulses - p0, 1);
    check("t1_seq", bus.seq, 32'h87654321);
    check("t1_blank", {24'b0, bus.blank}, 32'h0);
    check("t1_bad", {24'b0, bus.bad}, 32'h0);

    // 2: short dwell on digit 3 holds the frame back
    p0 = pulses;
    for (int i = 0; i < 8; i++) dwell(i, {1'b0, seg_tab[i]}, (i == 3) ? S - 1 : 6);
    idle(2);
    check("t2_no_pulse", pulses - p0, 0);
    dwell(3, {1'b0, seg_tab[3]}, 6);
    idle(2);
    check("t2_pulse", pulses - p0, 1);
    check("t2_seq", bus.seq, 32'h76543210);

    // 3: two-hot select never commits and leaves the mask alone
    p0 = pulses;
    for (int i = 0; i < 7; i++) dwell(i, {1'b0, seg_tab[9]}, 6);
    for (int k = 0; k < 20; k++) cyc({1'b0, seg_tab[9]}, 8'h05, 1'b1);
    check("t3_no_pulse", pulses - p0, 0);
    dwell(7, {1'b0, seg_tab[9]}, 6);
    idle(2);
    check("t3_pulse", pulses - p0, 1);
    check("t3_seq", bus.seq, 32'h99999999);

    // 4: blank and undecodable digits
    for (int i = 0; i < 8; i++)
      dwell(i, (i == 2) ? 8'h00 : (i == 5) ? 8'h49 : 8'h7F, 6);
    idle(2);
    check("t4_seq", bus.seq, 32'h88088088);
    check("t4_blank", {24'b0, bus.blank}, 32'h04);
    check("t4_bad", {24'b0, bus.bad}, 32'h20);

    // 5: latest capture of a digit wins
    dwell(0, 8'h06, 6);
    dwell(0, 8'h5B, 6);
    for (int i = 1; i < 8; i++) dwell(i, {1'b0, seg_tab[i]}, 6);
    idle(2);
    check("t5_nib0", {28'b0, bus.seq[3:0]}, 32'h2);
    check("t5_seq", bus.seq, 32'h76543212);

    // 6: reset mid-frame discards the partial frame
    for (int i = 0; i < 5; i++) dwell(i, {1'b0, seg_tab[i+5]}, 6);
    cyc(8'h00, 8'h00, 1'b0);
    check("t6_seq", bus.seq, 32'h0);
    check("t6_blank", {24'b0, bus.blank}, 32'h0);
    check("t6_bad", {24'b0, bus.bad}, 32'h0);
    p0 = pulses;
    for (int i = 0; i < 8; i++) dwell(i, {1'b0, seg_tab[15-i]}, 6);
    idle(2);
    check("t6_pulses", pulses - p0, 1);
    check("t6_seq", bus.seq, 32'h89ABCDEF);

    // Random dwells, including dp noise, bad selects, odd patterns and resets
    for (int n = 0; n < 400; n++) begin
      d = 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) d = 8'($urandom);
      case ($urandom_range(0, 4))
        0:       s = 8'h00;
        1:       s = 8'($urandom);
        default: s = {1'b0, seg_tab[$urandom_range(0, 15)]};
      endcase
      s[7] = 1'($urandom);
      if ($urandom_range(0, 39) == 0) cyc(s, d, 1'b0);
      dwell(0, 8'h00, 0);
      for (int k = 0, len = $urandom_range(1, 8); k < len; k++) cyc(s, d, 1'b1);
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
